// File: rtl/bus_xfer_controller_if.sv
// Handshake and register-bank bus bundle for bus_xfer_controller.
// The controller connects through the slave modport; requesters and the
// register bank (or a testbench standing in for them) use the master modport.
interface bus_xfer_controller_if #(
    parameter int NUM_REGS = 8,
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_src;
    logic [NUM_REQ*IDX_W-1:0] req_dst;
    logic [NUM_REQ-1:0]       req_ack;
    logic                     req_err;
    logic [NUM_REGS-1:0]      reg_enable;
    logic [NUM_REGS-1:0]      reg_load;
    logic                     busy;

    modport master (
        output req_valid, req_src, req_dst,
        input  req_ack, req_err, reg_enable, reg_load, busy
    );

    modport slave (
        input  req_valid, req_src, req_dst,
        output req_ack, req_err, reg_enable, reg_load, busy
    );
endinterface

// File: rtl/bus_xfer_controller.sv
// bus_xfer_controller: round-robin sequencer for register-to-register moves
// over a shared tristate data bus. At most one register drives the bus and
// at most one register loads in any cycle.
//
// Build option BUS_XFER_SETTLE_EN:
//   defined   - a DRIVE (bus settle) cycle precedes LATCH; 3 cycles per move.
//   undefined - IDLE goes straight to LATCH; enable and load assert together;
//               2 cycles per move.
// The ERR path and the arbitration are identical in both builds.
//
// All outputs are flops loaded from the next-state decode, so they are a
// pure function of the registered state and captured src/dst/grant and
// never follow req_* combinationally within a cycle.

module bus_xfer_controller #(
    parameter int NUM_REGS = 8,
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bus_xfer_controller_if.slave   bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REGS_X = (IDX_W+1)'(NUM_REGS);

`ifdef BUS_XFER_SETTLE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_ERR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd2,
        ST_ERR   = 2'd3
    } state_t;
`endif

    // One-hot register select from a register index.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    // One-hot requester select from a grant index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (idx == PTR_W'(i));
        end
        return v;
    endfunction

    // An index is usable only if it addresses an existing register.
    function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < NUM_REGS_X);
    endfunction

    state_t               state_r, state_s;
    logic [PTR_W-1:0]     ptr_r, ptr_s;
    logic [PTR_W-1:0]     grant_r, grant_s;
    logic [IDX_W-1:0]     src_r, src_s;
    logic [IDX_W-1:0]     dst_r, dst_s;

    logic                 found_s;
    logic                 hit_s;
    int                   cand_idx_s;
    logic [PTR_W-1:0]     cand_grant_s;
    logic [PTR_W-1:0]     cand_ptr_s;
    logic [IDX_W-1:0]     cand_src_s;
    logic [IDX_W-1:0]     cand_dst_s;
    logic                 cand_bad_s;

    logic [NUM_REGS-1:0]  enable_r, enable_s;
    logic [NUM_REGS-1:0]  load_r, load_s;
    logic [NUM_REQ-1:0]   ack_r, ack_s;
    logic                 err_r, err_s;
    logic                 busy_r, busy_s;

    // Round-robin search: first valid requester at or after the pointer, cyclically.
    always_comb begin
        found_s      = 1'b0;
        hit_s        = 1'b0;
        cand_idx_s   = 0;
        cand_grant_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx_s   = int'(ptr_r) + k;
            cand_idx_s   = (cand_idx_s >= NUM_REQ) ? (cand_idx_s - NUM_REQ) : cand_idx_s;
            hit_s        = !found_s && bus.req_valid[cand_idx_s];
            cand_grant_s = hit_s ? PTR_W'(cand_idx_s) : cand_grant_s;
            found_s      = found_s | hit_s;
        end
        cand_src_s = bus.req_src[int'(cand_grant_s)*IDX_W +: IDX_W];
        cand_dst_s = bus.req_dst[int'(cand_grant_s)*IDX_W +: IDX_W];
        cand_bad_s = (cand_src_s == cand_dst_s) || !idx_legal(cand_src_s) || !idx_legal(cand_dst_s);
        cand_ptr_s = (cand_grant_s == PTR_W'(NUM_REQ - 1)) ? PTR_W'(0) : (cand_grant_s + PTR_W'(1));
    end

    // Next-state logic and capture of the granted request.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        grant_s = grant_r;
        src_s   = src_r;
        dst_s   = dst_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    grant_s = cand_grant_s;
                    src_s   = cand_src_s;
                    dst_s   = cand_dst_s;
                    ptr_s   = cand_ptr_s;
                    if (cand_bad_s) begin
                        state_s = ST_ERR;
                    end else begin
`ifdef BUS_XFER_SETTLE_EN
                        state_s = ST_DRIVE;
`else
                        state_s = ST_LATCH;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef BUS_XFER_SETTLE_EN
            ST_DRIVE: state_s = ST_LATCH;
`endif
            ST_LATCH: state_s = ST_IDLE;
            ST_ERR:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Output decode for the state being entered, so the flops present it during that state.
    always_comb begin
        enable_s = '0;
        load_s   = '0;
        ack_s    = '0;
        err_s    = 1'b0;
        busy_s   = (state_s != ST_IDLE);
        case (state_s)
`ifdef BUS_XFER_SETTLE_EN
            ST_DRIVE: begin
                enable_s = reg_onehot(src_s);
            end
`endif
            ST_LATCH: begin
                enable_s = reg_onehot(src_s);
                load_s   = reg_onehot(dst_s);
                ack_s    = req_onehot(grant_s);
            end
            ST_ERR: begin
                ack_s = req_onehot(grant_s);
                err_s = 1'b1;
            end
            ST_IDLE: begin
                enable_s = '0;
            end
            default: begin
                enable_s = '0;
            end
        endcase
    end

    // State, pointer, captured request and registered outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            grant_r  <= '0;
            src_r    <= '0;
            dst_r    <= '0;
            enable_r <= '0;
            load_r   <= '0;
            ack_r    <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            grant_r  <= grant_s;
            src_r    <= src_s;
            dst_r    <= dst_s;
            enable_r <= enable_s;
            load_r   <= load_s;
            ack_r    <= ack_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.reg_enable = enable_r;
    assign bus.reg_load   = load_r;
    assign bus.req_ack    = ack_r;
    assign bus.req_err    = err_r;
    assign bus.busy       = busy_r;

    bus_xfer_controller_chk #(
        .NUM_REGS (NUM_REGS),
        .NUM_REQ  (NUM_REQ)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .reg_enable (enable_r),
        .reg_load   (load_r),
        .req_ack    (ack_r)
    );

endmodule

// Bus-safety invariants: single driver, single loader, single ack, and a
// register never loads from its own drive.
module bus_xfer_controller_chk #(
    parameter int NUM_REGS = 8,
    parameter int NUM_REQ  = 4
) (
    input logic                clk,
    input logic                rst_n,
    input logic [NUM_REGS-1:0] reg_enable,
    input logic [NUM_REGS-1:0] reg_load,
    input logic [NUM_REQ-1:0]  req_ack
);
    a_enable_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(reg_enable));
    a_load_onehot0:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(reg_load));
    a_ack_onehot0:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ack));
    a_no_self_load:   assert property (@(posedge clk) disable iff (!rst_n) ((reg_enable & reg_load) == '0));
endmodule

// File: tb/tb_bus_xfer_controller.sv
// Scoreboard bench for bus_xfer_controller. A transaction-level model grants
// requests round-robin and queues the expected transfer with its ack cycle;
// a monitor derives the expected outputs for every cycle from the queue head.
module tb_bus_xfer_controller;
    localparam int NUM_REGS = 8;
    localparam int NUM_REQ  = 4;
    localparam int IDX_W    = 3;
`ifdef BUS_XFER_SETTLE_EN
    localparam bit SETTLE = 1'b1;
`else
    localparam bit SETTLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_xfer_controller_if #(.NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus_if ();

    bus_xfer_controller #(.NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        int grant;
        int src;
        int dst;
        bit err;
        int ack_cyc;
    } xfer_t;

    xfer_t exp_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    bit    pend [NUM_REQ];
    int    rq_src [NUM_REQ];
    int    rq_dst [NUM_REQ];
    int    rq_done [NUM_REQ];
    int    ptr_m = 0;
    int    free_cyc = 0;

    // cycle numbering: cycle n is the interval after the n-th rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: expected outputs of this cycle come from the head transfer
    xfer_t        mr;
    logic [7:0]   e_en, e_ld;
    logic [3:0]   e_ack;
    logic         e_err, e_busy;
    always @(negedge clk) begin
        if (mon_en) begin
            e_en = 8'h00; e_ld = 8'h00; e_ack = 4'h0; e_err = 1'b0; e_busy = 1'b0;
            if (exp_q.size() > 0) begin
                mr = exp_q[0];
                if (mr.ack_cyc == cyc) begin
                    e_ack  = 4'(1) << mr.grant;
                    e_err  = mr.err;
                    e_busy = 1'b1;
                    if (!mr.err) begin
                        e_en = 8'(1) << mr.src;
                        e_ld = 8'(1) << mr.dst;
                    end
                end else if (SETTLE && !mr.err && (mr.ack_cyc - 1 == cyc)) begin
                    e_en   = 8'(1) << mr.src;
                    e_busy = 1'b1;
                end
            end
            checks++;
            if ({bus_if.reg_enable, bus_if.reg_load, bus_if.req_ack, bus_if.req_err, bus_if.busy}
                !== {e_en, e_ld, e_ack, e_err, e_busy}) begin
                errors++;
                $display("FAIL outputs cyc=%0d got en=%h load=%h ack=%b err=%b busy=%b want en=%h load=%h ack=%b err=%b busy=%b",
                         cyc, bus_if.reg_enable, bus_if.reg_load, bus_if.req_ack, bus_if.req_err, bus_if.busy,
                         e_en, e_ld, e_ack, e_err, e_busy);
            end
            if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) void'(exp_q.pop_front());
        end
    end

    task automatic raise(input int i, input int s, input int d);
        pend[i]    = 1'b1;
        rq_src[i]  = s;
        rq_dst[i]  = d;
        rq_done[i] = -1;
    endtask

    task automatic raise_legal(input int i);
        int s;
        s = $urandom_range(0, 7);
        raise(i, s, (s + 1 + $urandom_range(0, 6)) % NUM_REGS);
    endtask

    // requesters drop valid in the cycle their ack is shown
    task automatic begin_cycle();
        @(negedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i] && rq_done[i] == cyc) pend[i] = 1'b0;
        end
    endtask

    // reference model: one transfer at a time, round-robin from the pointer
    task automatic model_grant();
        int    g;
        int    c;
        xfer_t x;
        g = -1;
        if (free_cyc <= cyc) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                c = (ptr_m + k) % NUM_REQ;
                if (g < 0 && pend[c]) g = c;
            end
            if (g >= 0) begin
                x.grant   = g;
                x.src     = rq_src[g];
                x.dst     = rq_dst[g];
                x.err     = (x.src == x.dst) || (x.src >= NUM_REGS) || (x.dst >= NUM_REGS);
                x.ack_cyc = cyc + ((x.err || !SETTLE) ? 1 : 2);
                exp_q.push_back(x);
                rq_done[g] = x.ack_cyc;
                free_cyc   = x.ack_cyc + 1;
                ptr_m      = (g + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic end_cycle();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus_if.req_valid[i] = pend[i];
            bus_if.req_src[i*IDX_W +: IDX_W] = IDX_W'(rq_src[i]);
            bus_if.req_dst[i*IDX_W +: IDX_W] = IDX_W'(rq_dst[i]);
        end
        if (rst_n) model_grant();
    endtask

    function automatic bit any_pend();
        bit a;
        a = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) a |= pend[i];
        return a;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        begin_cycle(); end_cycle();
        while ((any_pend() || free_cyc > cyc) && n < 40) begin
            begin_cycle(); end_cycle();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL wait_idle timeout cyc=%0d got still_busy want idle within 40 cycles", cyc);
        end
    endtask

    // one-cycle synchronous reset; transfers not yet acked are abandoned
    task automatic do_reset();
        begin_cycle();
        rst_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        for (int j = exp_q.size() - 1; j >= 0; j--) begin
            if (exp_q[j].ack_cyc > cyc) exp_q.delete(j);
        end
        ptr_m    = 0;
        free_cyc = cyc + 1;
        end_cycle();
        begin_cycle();
        rst_n = 1'b1;
        end_cycle();
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; rq_src[i] = 0; rq_dst[i] = 0; rq_done[i] = -1;
        end
        bus_if.req_valid = '0;
        bus_if.req_src   = '0;
        bus_if.req_dst   = '0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (3) begin begin_cycle(); end_cycle(); end
        begin_cycle();
        rst_n = 1'b1;
        end_cycle();
        wait_idle();

        // single legal move 2 -> 5 by requester 0
        begin_cycle(); raise(0, 2, 5); end_cycle();
        wait_idle();

        // illegal move 3 -> 3 by requester 1
        begin_cycle(); raise(1, 3, 3); end_cycle();
        wait_idle();

        // pointer now 2: requesters 0 and 1 together -> 0 first, then 1
        begin_cycle(); raise(0, 4, 6); raise(1, 6, 4); end_cycle();
        wait_idle();

        // all four held valid continuously
        begin_cycle();
        for (int i = 0; i < NUM_REQ; i++) raise_legal(i);
        end_cycle();
        repeat (16) begin
            begin_cycle();
            for (int i = 0; i < NUM_REQ; i++) if (!pend[i]) raise_legal(i);
            end_cycle();
        end
        wait_idle();

        // reset in the cycle after the grant of 1 -> 6
        begin_cycle(); raise(2, 1, 6); end_cycle();
        do_reset();
        wait_idle();

        // random traffic with occasional errors and resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                begin_cycle();
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!pend[i] && $urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 7) == 0) begin
                            rq_src[i] = $urandom_range(0, 7);
                            raise(i, rq_src[i], rq_src[i]);
                        end else begin
                            raise(i, $urandom_range(0, 7), $urandom_range(0, 7));
                        end
                    end
                end
                end_cycle();
            end
        end
        wait_idle();
        repeat (2) begin begin_cycle(); end_cycle(); end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending transfers want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
